sha256_padder: RTL

//  Producer side of the 512-bit block interface consumed by the SHA-256 compression core.

---
 rtl/sha256_padder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs a byte stream into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit big-endian bit length, and hands blocks out over valid/ready.
module sha256_padder #(
    parameter int BYTE_CNT_W = 61
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {FILL, PAD, LEN, EMIT} state_t;

    state_t                  state_reg, state_next;
    logic [6:0]              pos_reg, pos_next;
    logic [BYTE_CNT_W-1:0]   count_reg, count_next;
    logic                    last_reg, last_next;
    logic                    pend_pad_reg, pend_pad_next;
    logic                    pend_len_reg, pend_len_next;
    logic                    first_reg, first_next;
    logic                    in_ready_reg, in_ready_next;
    logic                    acc, pad_wr, len_wr, lead_wr, blk_hs;
    logic [63:0]             len64;

    assign len64 = 64'({count_reg, 3'b000});

    always_comb begin
        state_next    = state_reg;
        pos_next      = pos_reg;
        count_next    = count_reg;
        last_next     = last_reg;
        pend_pad_next = pend_pad_reg;
        pend_len_next = pend_len_reg;
        first_next    = first_reg;
        acc           = 1'b0;
        pad_wr        = 1'b0;
        len_wr        = 1'b0;
        lead_wr       = 1'b0;
        blk_hs        = 1'b0;
        case (state_reg)
            FILL: begin
                if (in_valid && in_ready_reg) begin
                    acc        = 1'b1;
                    pos_next   = pos_reg + 7'd1;
                    count_next = count_reg + BYTE_CNT_W'(1);
                    if (in_last) begin
                        if (pos_reg == 7'd63) begin
                            // No room for 0x80 here; it leads the follow-on block.
                            state_next    = EMIT;
                            last_next     = 1'b0;
                            pend_pad_next = 1'b1;
                        end else begin
                            state_next = PAD;
                        end
                    end else if (pos_reg == 7'd63) begin
                        state_next = EMIT;
                        last_next  = 1'b0;
                    end
                end
            end
            PAD: begin
                pad_wr     = 1'b1;
                state_next = EMIT;
                if (pos_reg <= 7'd55) begin
                    len_wr    = 1'b1;
                    last_next = 1'b1;
                end else begin
                    last_next     = 1'b0;
                    pend_len_next = 1'b1;
                end
            end
            LEN: begin
                len_wr        = 1'b1;
                lead_wr       = pend_pad_reg;
                pend_pad_next = 1'b0;
                pend_len_next = 1'b0;
                last_next     = 1'b1;
                state_next    = EMIT;
            end
            EMIT: begin
                if (blk_ready) begin
                    blk_hs     = 1'b1;
                    pos_next   = 7'd0;
                    first_next = last_reg;
                    last_next  = 1'b0;
                    if (pend_pad_reg || pend_len_reg) begin
                        state_next = LEN;
                    end else begin
                        state_next = FILL;
                        if (last_reg)
                            count_next = '0;
                    end
                end
            end
            default: state_next = FILL;
        endcase
        in_ready_next = (state_next == FILL) && !pos_next[6];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FILL;
            pos_reg      <= 7'd0;
            count_reg    <= '0;
            last_reg     <= 1'b0;
            pend_pad_reg <= 1'b0;
            pend_len_reg <= 1'b0;
            first_reg    <= 1'b1;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pos_reg      <= pos_next;
            count_reg    <= count_next;
            last_reg     <= last_next;
            pend_pad_reg <= pend_pad_next;
            pend_len_reg <= pend_len_next;
            first_reg    <= first_next;
            in_ready_reg <= in_ready_next;
        end
    end

    // One register per buffer byte so every byte can be cleared on handshake in parallel.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_byte
            localparam bit IS_LEN  = (gi >= 56);
            localparam bit IS_HEAD = (gi == 0);
            logic [7:0] byte_reg;
            logic [7:0] len_byte;

            if (gi >= 56) begin : g_len
                assign len_byte = len64[8*(63-gi) +: 8];
            end else begin : g_nolen
                assign len_byte = 8'h00;
            end

            always_ff @(posedge clk) begin
                if (rst || blk_hs)
                    byte_reg <= 8'h00;
                else if (acc && pos_reg == 7'(gi))
                    byte_reg <= in_data;
                else if (pad_wr && pos_reg == 7'(gi))
                    byte_reg <= 8'h80;
                else if (len_wr && IS_LEN)
                    byte_reg <= len_byte;
                else if (lead_wr && IS_HEAD)
                    byte_reg <= 8'h80;
            end

            assign blk_data[511-8*gi -: 8] = byte_reg;
        end
    endgenerate

    assign in_ready  = in_ready_reg;
    assign blk_valid = (state_reg == EMIT);
    assign blk_first = blk_valid && first_reg;
    assign blk_last  = blk_valid && last_reg;

endmodule
